// File: rtl/q4_logic_pkg.sv
// Shared constants for the q4 logic pair: truth tables of F (majority) and G (prime),
// bit n of each constant is the function value at input index n = {x1,x2,x3,x4,x5}.
package q4_logic_pkg;

  localparam int          N_W        = 5;
  localparam logic [31:0] F_MINTERMS = 32'hFEE8_E880;
  localparam logic [31:0] G_MINTERMS = 32'hA08A_28AC;

endpackage

// File: rtl/q4_logic_pair_if.sv
// Input vector x1..x5 (x1 = MSB) and the two flag outputs of the q4 logic pair.
interface q4_logic_pair_if;

  logic x1;
  logic x2;
  logic x3;
  logic x4;
  logic x5;
  logic ffinal;
  logic gfinal;

  modport master (
    output x1, x2, x3, x4, x5,
    input  ffinal, gfinal
  );

  modport slave (
    input  x1, x2, x3, x4, x5,
    output ffinal, gfinal
  );

endinterface

// File: rtl/q4_logic_core.sv
// Minimised sum-of-products for F (5-input majority) and G (prime detector on n = {x1..x5}).
// Purely combinational, zero latency, no flow control.
module q4_logic_core
  import q4_logic_pkg::*;
(
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  input  logic x5,
  output logic f,
  output logic g
);

  // Majority: every 3-of-5 product term; none of the ten can be merged.
  assign f = (x1 & x2 & x3) | (x1 & x2 & x4) | (x1 & x2 & x5) |
             (x1 & x3 & x4) | (x1 & x3 & x5) | (x1 & x4 & x5) |
             (x2 & x3 & x4) | (x2 & x3 & x5) | (x2 & x4 & x5) |
             (x3 & x4 & x5);

  // Primes {2,3},{5,7},{3,11},{13,29},{17,19},{23,31}: six cubes cover all eleven.
  assign g = (~x1 & ~x2 & ~x3 &  x4      ) |
             (~x1 & ~x2 &  x3 &       x5 ) |
             (~x1 & ~x3 &  x4 &  x5      ) |
             ( x2 &  x3 & ~x4 &  x5      ) |
             ( x1 & ~x2 & ~x3 &  x5      ) |
             ( x1 &  x3 &  x4 &  x5      );

endmodule

// File: rtl/q4_logic_pair.sv
// Majority/prime flag pair; REG_OUT=1 registers both flags (1-cycle latency, async clear),
// REG_OUT=0 drives them straight from the core (0 latency). No handshake: every cycle samples.
module q4_logic_pair
  import q4_logic_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  q4_logic_pair_if.slave  bus
);

  logic f;
  logic g;

  q4_logic_core u_core (
    .x1 (bus.x1),
    .x2 (bus.x2),
    .x3 (bus.x3),
    .x4 (bus.x4),
    .x5 (bus.x5),
    .f  (f),
    .g  (g)
  );

  generate
    if (REG_OUT) begin : g_reg
      logic f_q;
      logic g_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          f_q <= 1'b0;
          g_q <= 1'b0;
        end else begin
          f_q <= f;
          g_q <= g;
        end
      end

      assign bus.ffinal = f_q;
      assign bus.gfinal = g_q;
    end else begin : g_comb
      // Clock and reset have no role in the bypass build.
      logic unused_clk_rst;
      assign unused_clk_rst = clk | rst;

      assign bus.ffinal = f;
      assign bus.gfinal = g;
    end
  endgenerate

endmodule

// File: tb/tb_q4_logic_pair.sv
// Bench for q4_logic_pair: registered and bypass builds side by side, checked against
// the package truth tables and a hand-written spot table.
module tb_q4_logic_pair;
  import q4_logic_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  q4_logic_pair_if bus_r ();
  q4_logic_pair_if bus_c ();

  q4_logic_pair #(.REG_OUT(1'b1)) dut_r (.clk(clk), .rst(rst), .bus(bus_r.slave));
  q4_logic_pair #(.REG_OUT(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(bus_c.slave));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] n;
    logic       f;
    logic       g;
  } vec_t;

  vec_t        spot [8];
  vec_t        sb [$];
  vec_t        e;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] fm;
  logic [31:0] gm;

  task automatic drive(input logic [4:0] n);
    {bus_r.x1, bus_r.x2, bus_r.x3, bus_r.x4, bus_r.x5} = n;
    {bus_c.x1, bus_c.x2, bus_c.x3, bus_c.x4, bus_c.x5} = n;
  endtask

  task automatic check(input string name, input int n, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s n=%0d: got f,g=%b need %b", name, n, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [4:0] n);
    vec_t v;
    v.n = n;
    v.f = fm[n];
    v.g = gm[n];
    return v;
  endfunction

  function automatic logic [1:0] rout();
    return {bus_r.ffinal, bus_r.gfinal};
  endfunction

  function automatic logic [1:0] cout();
    return {bus_c.ffinal, bus_c.gfinal};
  endfunction

  initial begin
    fm = F_MINTERMS;
    gm = G_MINTERMS;
    spot[0] = '{n: 5'd0,  f: 1'b0, g: 1'b0};
    spot[1] = '{n: 5'd3,  f: 1'b0, g: 1'b1};
    spot[2] = '{n: 5'd7,  f: 1'b1, g: 1'b1};
    spot[3] = '{n: 5'd9,  f: 1'b0, g: 1'b0};
    spot[4] = '{n: 5'd15, f: 1'b1, g: 1'b0};
    spot[5] = '{n: 5'd17, f: 1'b0, g: 1'b1};
    spot[6] = '{n: 5'd28, f: 1'b1, g: 1'b0};
    spot[7] = '{n: 5'd31, f: 1'b1, g: 1'b1};

    // Reset held with all-ones input: registered outputs stay clear across edges.
    drive(5'd31);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_hold", 31, rout(), 2'b00);
    end
    check("bypass_ignores_rst", 31, cout(), 2'b11);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_before_edge", 31, rout(), 2'b00);
    @(posedge clk);
    #1;
    check("first_edge_after_reset", 31, rout(), 2'b11);

    // Exhaustive sweep through the scoreboard; bypass build checked before the edge.
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      drive(n[4:0]);
      sb.push_back(model(n[4:0]));
      #1;
      check("sweep_bypass", n, cout(), {fm[n], gm[n]});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("sweep_reg", int'(e.n), rout(), {e.f, e.g});
    end

    // Spot values from the hand-written table.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(spot[i].n);
      @(posedge clk);
      #1;
      check("spot_reg", int'(spot[i].n), rout(), {spot[i].f, spot[i].g});
    end

    // Latency: value appears only after its own edge.
    @(negedge clk);
    drive(5'd7);
    @(posedge clk);
    #1;
    check("latency_first", 7, rout(), 2'b11);
    @(negedge clk);
    drive(5'd0);
    #1;
    check("latency_hold", 0, rout(), 2'b11);
    @(posedge clk);
    #1;
    check("latency_second", 0, rout(), 2'b00);

    // Mid-stream reset pulsed between edges.
    @(negedge clk);
    drive(5'd13);
    @(posedge clk);
    #1;
    check("midrst_before", 13, rout(), 2'b11);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_async_clear", 13, rout(), 2'b00);
    check("midrst_bypass", 13, cout(), 2'b11);
    @(posedge clk);
    #1;
    check("midrst_hold", 13, rout(), 2'b00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_released_no_stale", 13, rout(), 2'b00);
    @(posedge clk);
    #1;
    check("midrst_recover", 13, rout(), 2'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
